rx_sym_slicer: RTL and testbench

// Receive-side counterpart of the transmit mapper/pulse-shaping filter. Takes the

---
 rtl/rx_pkg.sv | 41 ++++
 rtl/rx_ref_tracker.sv | 59 +++++
 rtl/rx_sym_slicer.sv | 118 +++++++++++
 tb/tb_rx_sym_slicer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// rx_pkg : sample width, 4-ASK symbol codes and saturation helpers
// Rev 1.0 - initial release
// ============================================================================
package rx_pkg;

  localparam int WIDTH = 18;

  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b10;
  localparam logic [1:0] SYM_P3 = 2'b11;

  // |x|; the most negative code has no positive twin and maps to full scale
  function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    if (!x[WIDTH-1]) begin
      r = x;
    end else if (x == {1'b1, {(WIDTH-1){1'b0}}}) begin
      r = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      r = ~x + 1'b1;
    end
    return r;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH+1:0] v);
    logic signed [WIDTH-1:0] r;
    if ((v[WIDTH+1:WIDTH-1] == 3'b000) || (v[WIDTH+1:WIDTH-1] == 3'b111)) begin
      r = v[WIDTH-1:0];
    end else if (v[WIDTH+1]) begin
      r = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_ref_tracker.sv
`default_nettype none
// ============================================================================
// rx_ref_tracker : block-average of |x| over 2**AVG_LOG2 symbols -> ref_lvl
// Rev 1.0 - initial release
// ============================================================================
module rx_ref_tracker #(
  parameter int WIDTH    = rx_pkg::WIDTH,
  parameter int AVG_LOG2 = 10,
  parameter int INIT_REF = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic             hold,
  input  logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] ref_lvl
);

  localparam int ACC_W = WIDTH + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] scnt_q, scnt_d, frac_unused;
  logic [WIDTH-1:0]    ref_q, ref_d, avg;

  always_comb begin
    sum = acc_q + ACC_W'(a_in);
    {avg, frac_unused} = sum;
    acc_d  = acc_q;
    scnt_d = scnt_q;
    ref_d  = ref_q;
    if (upd && !hold) begin
      if (&scnt_q) begin
        acc_d  = '0;
        scnt_d = '0;
        // a zero threshold would collapse the slicer, so floor it at 1
        ref_d  = (avg == '0) ? WIDTH'(1) : avg;
      end else begin
        acc_d  = sum;
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      scnt_q <= '0;
      ref_q  <= WIDTH'(INIT_REF);
    end else begin
      acc_q  <= acc_d;
      scnt_q <= scnt_d;
      ref_q  <= ref_d;
    end
  end

  assign ref_lvl = ref_q;

endmodule
`default_nettype wire

// File: rtl/rx_sym_slicer.sv
`default_nettype none
// ============================================================================
// rx_sym_slicer : decimate matched-filter output, slice to 4-ASK, report error
// Rev 1.0 - initial release
// ============================================================================
module rx_sym_slicer #(
  parameter int WIDTH    = rx_pkg::WIDTH,
  parameter int SPS      = 4,
  parameter int AVG_LOG2 = 10,
  parameter int INIT_REF = 65536,
  localparam int CNT_W   = (SPS > 1) ? $clog2(SPS) : 1
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    sam_clk_en,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic [CNT_W-1:0]        phase,
  input  logic                    hold_ref,
  output logic [1:0]              sym_out,
  output logic                    sym_valid,
  output logic signed [WIDTH-1:0] err,
  output logic [WIDTH-1:0]        ref_lvl
);

  import rx_pkg::*;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] x_s_q, x_s_d;
  logic                    cap_v_q, cap_v_d;
  logic [1:0]              sym_q, sym_d;
  logic                    valid_q, valid_d;
  logic signed [WIDTH-1:0] err_q, err_d;

  logic signed [WIDTH+1:0] x_ext, ref_ext, half_ext, ideal, diff;
  logic [1:0]              slice_sym;

  // sample counter and decimating capture
  always_comb begin
    cnt_d   = cnt_q;
    x_s_d   = x_s_q;
    cap_v_d = 1'b0;
    if (sam_clk_en) begin
      cnt_d = (cnt_q == CNT_W'(SPS - 1)) ? '0 : cnt_q + 1'b1;
      if (cnt_q == phase) begin
        x_s_d   = x_in;
        cap_v_d = 1'b1;
      end
    end
  end

  // two guard bits: ideal levels reach 1.5 * full-scale ref
  always_comb begin
    x_ext    = {{2{x_s_q[WIDTH-1]}}, x_s_q};
    ref_ext  = {2'b00, ref_lvl};
    half_ext = {3'b000, ref_lvl[WIDTH-1:1]};
    if (x_ext >= ref_ext) begin
      slice_sym = SYM_P3;
      ideal     = ref_ext + half_ext;
    end else if (!x_ext[WIDTH+1]) begin
      slice_sym = SYM_P1;
      ideal     = half_ext;
    end else if (x_ext >= -ref_ext) begin
      slice_sym = SYM_M1;
      ideal     = -half_ext;
    end else begin
      slice_sym = SYM_M3;
      ideal     = -(ref_ext + half_ext);
    end
    diff = x_ext - ideal;
  end

  always_comb begin
    sym_d   = sym_q;
    err_d   = err_q;
    valid_d = cap_v_q;
    if (cap_v_q) begin
      sym_d = slice_sym;
      err_d = sat(diff);
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      x_s_q   <= '0;
      cap_v_q <= 1'b0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      x_s_q   <= x_s_d;
      cap_v_q <= cap_v_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  rx_ref_tracker #(
    .WIDTH    (WIDTH),
    .AVG_LOG2 (AVG_LOG2),
    .INIT_REF (INIT_REF)
  ) u_ref_tracker (
    .clk     (sys_clk),
    .rst     (reset),
    .upd     (cap_v_q),
    .hold    (hold_ref),
    .a_in    (abs_sat(x_s_q)),
    .ref_lvl (ref_lvl)
  );

  assign sym_out   = sym_q;
  assign sym_valid = valid_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_sym_slicer.sv
`default_nettype none
// ============================================================================
// tb_rx_sym_slicer : directed self-checking bench for rx_sym_slicer
// Rev 1.0 - initial release
// ============================================================================
module tb_rx_sym_slicer;

  logic               sys_clk = 1'b0;
  logic               reset;
  logic               sam_clk_en;
  logic signed [17:0] x_in;
  logic [1:0]         phase;
  logic               hold_ref;
  logic [1:0]         sym_out;
  logic               sym_valid;
  logic signed [17:0] err;
  logic [17:0]        ref_lvl;

  int errors = 0;
  int checks = 0;

  rx_sym_slicer #(
    .WIDTH    (18),
    .SPS      (4),
    .AVG_LOG2 (4),
    .INIT_REF (65536)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .x_in       (x_in),
    .phase      (phase),
    .hold_ref   (hold_ref),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .err        (err),
    .ref_lvl    (ref_lvl)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // One symbol at phase 0, entered when the sample counter is at 0.
  task automatic sym_check(input string tag, input int x, input int exp_sym,
                           input int exp_err, input int exp_ref);
    x_in = x[17:0];
    step();
    chk({tag, "_pre_valid"}, sym_valid, 0);
    step();
    chk({tag, "_valid"}, sym_valid, 1);
    chk({tag, "_sym"}, sym_out, exp_sym);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_ref"}, ref_lvl, exp_ref);
    step();
    chk({tag, "_post_valid"}, sym_valid, 0);
    chk({tag, "_hold_sym"}, sym_out, exp_sym);
    step();
  endtask

  initial begin
    reset      = 1'b1;
    sam_clk_en = 1'b0;
    x_in       = '0;
    phase      = 2'd0;
    hold_ref   = 1'b1;
    repeat (3) step();
    chk("rst_sym", sym_out, 0);
    chk("rst_valid", sym_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_ref", ref_lvl, 65536);

    reset      = 1'b0;
    sam_clk_en = 1'b1;

    // constant +0.75
    sym_check("const0", 98304, 3, 0, 65536);
    sym_check("const1", 98304, 3, 0, 65536);
    sym_check("const2", 98304, 3, 0, 65536);

    // threshold ties at ref = 65536
    sym_check("tie_p65536", 65536, 3, -32768, 65536);
    sym_check("tie_p65535", 65535, 2, 32767, 65536);
    sym_check("tie_zero", 0, 2, -32768, 65536);
    sym_check("tie_m1", -1, 1, 32767, 65536);
    sym_check("tie_m65536", -65536, 1, -32768, 65536);
    sym_check("tie_m65537", -65537, 0, 32767, 65536);

    // most negative input
    sym_check("sat_min", -131072, 0, -32768, 65536);

    // reference tracking over a 16-symbol window
    hold_ref = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) sym_check("avg40k_pos", 40000, 2, 7232, (i == 15) ? 40000 : 65536);
      else            sym_check("avg40k_neg", -40000, 1, -7232, (i == 15) ? 40000 : 65536);
    end
    hold_ref = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) sym_check("hold20k_pos", 20000, 2, 0, 40000);
      else            sym_check("hold20k_neg", -20000, 1, 0, 40000);
    end
    hold_ref = 1'b0;
    for (int i = 0; i < 16; i++)
      sym_check("avg_abs_sat", -131072, 0, -71072, (i == 15) ? 131071 : 40000);
    sym_check("full_ref", -131072, 0, 65534, 131071);

    // asynchronous reset with a capture in flight
    hold_ref = 1'b1;
    x_in     = 18'sd777;
    step();
    reset = 1'b1;
    #1;
    chk("midrst_valid", sym_valid, 0);
    chk("midrst_sym", sym_out, 0);
    chk("midrst_err", err, 0);
    chk("midrst_ref", ref_lvl, 65536);
    step();
    chk("midrst_held_valid", sym_valid, 0);
    reset = 1'b0;
    chk("midrst_release_valid", sym_valid, 0);
    sym_check("post_rst", 98304, 3, 0, 65536);

    // phase selection on a ramp, switching phase mid-symbol
    begin
      logic prev_cap;
      int   prev_x;
      int   ph;
      prev_cap = 1'b0;
      prev_x   = 0;
      for (int k = 0; k < 24; k++) begin
        ph    = (k < 13) ? 2 : 0;
        phase = ph[1:0];
        x_in  = k[17:0];
        step();
        chk("ramp_valid", sym_valid, prev_cap);
        if (prev_cap) begin
          chk("ramp_sym", sym_out, 2);
          chk("ramp_err", err, prev_x - 32768);
        end
        prev_cap = ((k % 4) == ph);
        prev_x   = k;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
